hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline.
- Drives the Execute-stage forwarding selects, and the load-use stall and branch/jump flush for Fetch, Decode and Execute.
- Sequences multi-cycle Execute operations with a FSM that freezes the front end and bubbles Memory until the operation completes or times out.
- Also keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, performance counter width.
- MC_TIMEOUT, 64, maximum MC_BUSY cycles before forced abort (must be >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  REG_AW  Decode source registers
- Rs1E, Rs2E  in  REG_AW  Execute source registers
- RdE, RdM, RdW  in  REG_AW  destination registers per stage
- ResultSrcE  in  2  Execute result source (2'b01 = load)
- RegWriteM, RegWriteW  in  1  register write enables
- PCSrcE  in  1  branch taken / jump in Execute
- McStartE  in  1  Execute holds a multi-cycle op
- McDoneE  in  1  multi-cycle unit result valid
- ForwardAE, ForwardBE  out  2  00 regfile, 01 WB result, 10 Mem ALU result
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  clear stage register to bubble
- McBusy  out  1  FSM in MC_BUSY
- McTimeout  out  1  one-cycle abort pulse
- StallCycles, FlushCycles  out  CNT_W  saturating counters

Behaviour:
- Reset: state IDLE, timeout counter 0, StallCycles=FlushCycles=0, McTimeout=0. While rst=1: FlushD=FlushE=FlushM=1, all stalls 0, Forward*=00, counters do not increment.
- Forwarding (combinational, per operand X in {A,B}, source RsXE):
  - 10 if RegWriteM && RdM!=0 && RdM==RsXE;
  - else 01 if RegWriteW && RdW!=0 && RdW==RsXE;
  - else 00.
  - Mem has priority over WB.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- mcStall = McStartE && !McDoneE, in IDLE or MC_BUSY.
- FSM:
  - IDLE -> MC_BUSY when mcStall.
  - MC_BUSY -> IDLE on McDoneE, or on timeout counter reaching MC_TIMEOUT-1. McTimeout=1 for that one cycle.
  - Timeout counter increments each MC_BUSY cycle and clears on leaving MC_BUSY.
- Output priority, highest first:
  1. mcStall (and not timing out): StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. lwStall and PCSrcE are ignored.
  2. PCSrcE: FlushD=FlushE=1, stalls 0.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. None of the above: all 0.
- Stall is combinational in the same cycle McStartE first rises, so zero extra latency.
- McStartE && McDoneE together in IDLE means single-cycle completion: no stall, no state change.
- Timeout cycle: stalls released, FlushE=1, so the aborted op is discarded.
- Counters, registered, saturating at all-ones:
  - StallCycles += 1 each cycle StallD=1.
  - FlushCycles += 1 each cycle FlushD=1.
- Reset mid-MC_BUSY: IDLE at the next edge, no McTimeout pulse.

Decomposition:
- Package pipeline_pkg:
  - RESULTSRC_LOAD=2'b01;
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - typedef enum logic {IDLE, MC_BUSY} mc_state_t.
- Sub-module forward_sel, combinational, instantiated twice (A and B). FSM and counters stay in hazard_ctrl.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Repeat with RdM=0 -> ForwardAE=01.
- ResultSrcE=01, RdE=3, Rs2D=3, one cycle -> StallF=StallD=FlushE=1 for exactly that cycle, StallCycles 0->1. Repeat with RdE=0 -> no stall.
- PCSrcE=1 with lwStall true -> FlushD=FlushE=1, StallF=StallD=0, FlushCycles increments.
- McStartE=1, McDoneE low for 4 cycles then high -> StallF/D/E=FlushM=1 for 4 cycles, McBusy high from cycle 2 to 5, IDLE after, StallCycles=4.
- McStartE held, McDoneE never -> McTimeout pulses once on cycle MC_TIMEOUT (64) with FlushE=1, stalls released, state IDLE.
- rst asserted during MC_BUSY -> next cycle McBusy=0, counters 0, FlushD/E/M=1 while rst high. Force 2^CNT_W+3 stall cycles -> StallCycles holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard logic.
//   RESULTSRC_LOAD : Execute result-source code for a load
//   FWD_*          : Execute operand forwarding select codes
//   mc_state_t     : multi-cycle sequencer states
package pipeline_pkg;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one Execute source operand.
//   rs                      : Execute source register
//   rd_m, reg_write_m       : Memory-stage destination / write enable
//   rd_w, reg_write_w       : Writeback-stage destination / write enable
//   fwd                     : FWD_MEM, FWD_WB or FWD_RF (Memory wins)
module forward_sel
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    // x0 is never forwarded; the younger (Memory) producer takes priority.
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline.
//   clk, rst                : clock, synchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E    : Decode / Execute source registers
//   RdE/RdM/RdW             : per-stage destination registers
//   ResultSrcE              : Execute result source (load detection)
//   RegWriteM/RegWriteW     : register write enables
//   PCSrcE                  : taken branch / jump in Execute
//   McStartE/McDoneE        : multi-cycle op present / result valid
//   ForwardAE/ForwardBE     : Execute operand forwarding selects
//   StallF/D/E, FlushD/E/M  : stage hold / bubble controls
//   McBusy, McTimeout       : sequencer busy, one-cycle abort pulse
//   StallCycles/FlushCycles : saturating performance counters
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic              McDoneE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McBusy,
    output logic              McTimeout,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushCycles
);

    localparam int unsigned TW = $clog2(MC_TIMEOUT);

    mc_state_t     state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [1:0]    fwd_a, fwd_b;
    logic          lw_stall, mc_stall, timeout;

    forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign McBusy = (state == MC_BUSY);

    // Next state, timeout counter and stage controls.
    // tcnt counts cycles of the current op, the IDLE entry cycle included,
    // so the abort lands on the MC_TIMEOUT-th cycle of the op.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = '0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        McTimeout = 1'b0;

        lw_stall = (ResultSrcE == RESULTSRC_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
        mc_stall = McStartE && !McDoneE;
        timeout  = (state == MC_BUSY) && !McDoneE &&
                   (tcnt == TW'(MC_TIMEOUT - 1));

        case (state)
            IDLE: begin
                if (mc_stall) begin
                    state_nxt = MC_BUSY;
                    tcnt_nxt  = TW'(1);
                end
            end
            MC_BUSY: begin
                if (McDoneE || timeout) begin
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (timeout) begin
            // Abort: release the front end and discard the op in Execute.
            McTimeout = 1'b1;
            FlushE    = 1'b1;
        end else if (mc_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end

        if (rst) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            McTimeout = 1'b0;
        end
    end

    // State, timeout counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            if (StallD && !(&StallCycles)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (FlushD && !(&FlushCycles)) begin
                FlushCycles <= FlushCycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned MC_TIMEOUT = 64;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]        ResultSrcE;
    logic              RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic              McBusy, McTimeout;
    logic [CNT_W-1:0]  StallCycles, FlushCycles;

    int checks = 0;
    int errors = 0;

    // Model state: whether an op is outstanding and which cycle of it we are on.
    bit m_busy = 0;
    int m_age  = 0;
    int m_sc   = 0;
    int m_fc   = 0;
    int tmo_seen = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McBusy(McBusy), .McTimeout(McTimeout),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd_of(input logic [REG_AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE} = '0;
    endtask

    // One clock: predict, compare mid-cycle, then advance the model.
    task automatic step();
        bit lw, mc, tmo;
        int fa, fb;
        bit sf, sd, se, fd, fe, fm;
        lw  = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        mc  = McStartE && !McDoneE;
        tmo = m_busy && !McDoneE && (m_age == int'(MC_TIMEOUT));
        fa = fwd_of(Rs1E);
        fb = fwd_of(Rs2E);
        {sf, sd, se, fd, fe, fm} = '0;
        if (rst) begin
            fa = 0; fb = 0; fd = 1; fe = 1; fm = 1; tmo = 0;
        end else if (tmo) begin
            fe = 1;
        end else if (mc) begin
            sf = 1; sd = 1; se = 1; fm = 1;
        end else if (PCSrcE) begin
            fd = 1; fe = 1;
        end else if (lw) begin
            sf = 1; sd = 1; fe = 1;
        end

        @(negedge clk);
        chk("ForwardAE", 32'(ForwardAE), 32'(fa));
        chk("ForwardBE", 32'(ForwardBE), 32'(fb));
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sd));
        chk("StallE", 32'(StallE), 32'(se));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("FlushM", 32'(FlushM), 32'(fm));
        chk("McBusy", 32'(McBusy), 32'(m_busy));
        chk("McTimeout", 32'(McTimeout), 32'(tmo));
        chk("StallCycles", 32'(StallCycles), 32'(m_sc));
        chk("FlushCycles", 32'(FlushCycles), 32'(m_fc));
        if (McTimeout === 1'b1) tmo_seen++;

        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_age = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (sd && m_sc < CNT_MAX) m_sc++;
            if (fd && m_fc < CNT_MAX) m_fc++;
            if (!m_busy) begin
                if (mc) begin m_busy = 1; m_age = 2; end
            end else if (McDoneE || tmo) begin
                m_busy = 0; m_age = 0;
            end else begin
                m_age++;
            end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;
        step(); step();
        rst = 1'b0;
        step();

        // Forwarding: Memory beats Writeback; x0 in Memory falls back to WB.
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
        step();
        chk("fwdA_mem_const", 32'(ForwardAE), 32'd2);
        RdM = 0;
        step();
        chk("fwdA_wb_const", 32'(ForwardAE), 32'd1);
        clear_inputs();

        // Load-use for one cycle, then with x0 destination.
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        step();
        RdE = 0;
        step();
        chk("lw_stallcnt_const", 32'(StallCycles), 32'd1);

        // Branch wins over load-use.
        RdE = 3; PCSrcE = 1;
        step();
        clear_inputs();
        step();

        // Multi-cycle op completing after 4 stall cycles.
        McStartE = 1;
        repeat (4) step();
        McDoneE = 1;
        step();
        clear_inputs();
        step();
        chk("mc_stallcnt_const", 32'(StallCycles), 32'd5);

        // Multi-cycle op that never completes: one abort pulse on cycle 64.
        tmo_seen = 0;
        McStartE = 1;
        repeat (MC_TIMEOUT) step();
        McStartE = 0;
        chk("tmo_pulses", 32'(tmo_seen), 32'd1);
        step();
        chk("tmo_idle", 32'(McBusy), 32'd0);

        // Reset in the middle of an op.
        McStartE = 1;
        repeat (3) step();
        rst = 1;
        step(); step();
        rst = 0;
        clear_inputs();
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) < 2);
            Rs1D       = REG_AW'($urandom_range(0, 3));
            Rs2D       = REG_AW'($urandom_range(0, 3));
            Rs1E       = REG_AW'($urandom_range(0, 3));
            Rs2E       = REG_AW'($urandom_range(0, 3));
            RdE        = REG_AW'($urandom_range(0, 3));
            RdM        = REG_AW'($urandom_range(0, 3));
            RdW        = REG_AW'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 99) < 15);
            McStartE   = ($urandom_range(0, 99) < 40);
            McDoneE    = ($urandom_range(0, 99) < 25);
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        // Saturate the stall counter with a held load-use hazard.
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        repeat ((1 << CNT_W) + 3) step();
        chk("stall_saturate", 32'(StallCycles), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
